// File: rtl/m_if_bpred.sv
// m_if_bpred: branch-prediction front end that sits ahead of the IF stage.
// It looks up the fetch PC in a direct-mapped BTB with 2-bit saturating
// direction counters and selects the next fetch PC. Branches resolved in Ex
// train the table, and a redirect is raised when a branch's outcome differs
// from the prediction it carried down the pipe.
//
// Ports:
//   w_clk, w_rst, w_ce        clock, async active-high reset, clock enable
//   w_fetch_pc                PC being fetched this cycle
//   w_pred_taken/_target      prediction for w_fetch_pc
//   w_next_pc                 PC to load at the next edge
//   w_upd_*                   resolution info for the branch in Ex
//   w_redirect, w_redirect_pc misprediction flush and the corrected PC
//   w_nbranch, w_nmiss        resolved-branch and misprediction counters
module m_if_bpred #(
  parameter int         IDX_W    = 6,
  parameter int         TAG_W    = 6,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_ce,
  input  logic [31:0] w_fetch_pc,
  output logic        w_pred_taken,
  output logic [31:0] w_pred_target,
  output logic [31:0] w_next_pc,
  input  logic        w_upd_valid,
  input  logic [31:0] w_upd_pc,
  input  logic        w_upd_taken,
  input  logic [31:0] w_upd_target,
  input  logic        w_upd_pred_taken,
  input  logic [31:0] w_upd_pred_target,
  output logic        w_redirect,
  output logic [31:0] w_redirect_pc,
  output logic [31:0] w_nbranch,
  output logic [31:0] w_nmiss
);

  localparam int N = 1 << IDX_W;

  logic [N-1:0]     valid;
  logic [TAG_W-1:0] tag_mem [N];
  logic [29:0]      tgt_mem [N];
  logic [1:0]       ctr_mem [N];

  logic [IDX_W-1:0] fetch_idx, upd_idx;
  logic [TAG_W-1:0] fetch_tag, upd_tag;
  logic             fetch_hit, upd_hit;
  logic             pred_taken_raw, redirect_raw;
  logic [31:0]      pred_target_raw, redirect_pc_raw;
  logic             upd_en, hit_wr, alloc;
  logic [1:0]       upd_ctr, ctr_next;

  assign fetch_idx = w_fetch_pc[IDX_W+1:2];
  assign fetch_tag = w_fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx   = w_upd_pc[IDX_W+1:2];
  assign upd_tag   = w_upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads the pre-edge table contents; no write-through from updates.
  assign fetch_hit       = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
  assign pred_taken_raw  = fetch_hit && ctr_mem[fetch_idx][1];
  assign pred_target_raw = fetch_hit ? {tgt_mem[fetch_idx], 2'b00} : 32'd0;

  // Target mismatch only matters when the branch was actually taken.
  assign redirect_raw = w_upd_valid &&
                        ((w_upd_taken != w_upd_pred_taken) ||
                         (w_upd_taken && (w_upd_target != w_upd_pred_target)));
  assign redirect_pc_raw = w_upd_taken ? w_upd_target : w_upd_pc + 32'd4;

  // Every combinational output is forced to zero while reset is held.
  always_comb begin
    w_pred_taken  = 1'b0;
    w_pred_target = 32'd0;
    w_redirect    = 1'b0;
    w_redirect_pc = 32'd0;
    w_next_pc     = 32'd0;
    if (!w_rst) begin
      w_pred_taken  = pred_taken_raw;
      w_pred_target = pred_target_raw;
      w_redirect    = redirect_raw;
      w_redirect_pc = redirect_pc_raw;
      if (redirect_raw)
        w_next_pc = redirect_pc_raw;
      else if (pred_taken_raw)
        w_next_pc = pred_target_raw;
      else
        w_next_pc = w_fetch_pc + 32'd4;
    end
  end

  assign upd_en  = w_ce && w_upd_valid;
  assign upd_hit = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign hit_wr  = upd_en && upd_hit;
  assign alloc   = upd_en && !upd_hit && w_upd_taken;
  assign upd_ctr = ctr_mem[upd_idx];

  always_comb begin
    ctr_next = upd_ctr;
    if (w_upd_taken) begin
      if (upd_ctr != 2'b11) ctr_next = upd_ctr + 2'd1;
    end else begin
      if (upd_ctr != 2'b00) ctr_next = upd_ctr - 2'd1;
    end
  end

  // Valid bits, counters and statistics carry reset; tag/target do not need it
  // because a cleared valid bit masks them.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      valid     <= '0;
      w_nbranch <= 32'd0;
      w_nmiss   <= 32'd0;
      for (int i = 0; i < N; i++) ctr_mem[i] <= 2'b00;
    end else begin
      if (alloc) begin
        valid[upd_idx]   <= 1'b1;
        ctr_mem[upd_idx] <= CTR_INIT;
      end else if (hit_wr) begin
        ctr_mem[upd_idx] <= ctr_next;
      end
      if (upd_en)
        w_nbranch <= w_nbranch + 32'd1;
      if (w_ce && redirect_raw)
        w_nmiss <= w_nmiss + 32'd1;
    end
  end

  always_ff @(posedge w_clk) begin
    if (alloc)
      tag_mem[upd_idx] <= upd_tag;
    if (alloc || (hit_wr && w_upd_taken))
      tgt_mem[upd_idx] <= w_upd_target[31:2];
  end

endmodule

// File: tb/tb_m_if_bpred.sv
module tb_m_if_bpred;

  logic        clk, rst, ce;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target, next_pc;
  logic        upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc, nbranch, nmiss;

  m_if_bpred dut (
    .w_clk(clk), .w_rst(rst), .w_ce(ce),
    .w_fetch_pc(fetch_pc),
    .w_pred_taken(pred_taken), .w_pred_target(pred_target), .w_next_pc(next_pc),
    .w_upd_valid(upd_valid), .w_upd_pc(upd_pc), .w_upd_taken(upd_taken),
    .w_upd_target(upd_target), .w_upd_pred_taken(upd_pred_taken),
    .w_upd_pred_target(upd_pred_target),
    .w_redirect(redirect), .w_redirect_pc(redirect_pc),
    .w_nbranch(nbranch), .w_nmiss(nmiss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_PT = 0, S_PTGT = 1, S_NPC = 2, S_RD = 3, S_RDPC = 4, S_NB = 5, S_NM = 6;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  logic strobe = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] sample(int sig);
    case (sig)
      S_PT:    return {31'd0, pred_taken};
      S_PTGT:  return pred_target;
      S_NPC:   return next_pc;
      S_RD:    return {31'd0, redirect};
      S_RDPC:  return redirect_pc;
      S_NB:    return nbranch;
      default: return nmiss;
    endcase
  endfunction

  // Monitor: pops every queued expectation when the stimulus marks outputs stable.
  initial begin
    exp_t it;
    logic [31:0] act;
    forever begin
      @(posedge strobe);
      while (sb.size() > 0) begin
        it  = sb.pop_front();
        act = sample(it.sig);
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic chk(input string n, input int s, input logic [31:0] e);
    exp_t it;
    it.name = n; it.sig = s; it.exp = e;
    sb.push_back(it);
  endtask

  task automatic fire();
    strobe = 1'b1;
    #1;
    strobe = 1'b0;
  endtask

  task automatic cyc(input logic [31:0] fpc);
    @(negedge clk);
    fetch_pc = fpc;
    upd_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; fetch_pc = 32'h100;
    upd(32'h200, 1'b1, 32'h180, 1'b0, 32'h0);
    #2;
    chk("rst_pred_taken", S_PT, 0);   chk("rst_next_pc", S_NPC, 0);
    chk("rst_redirect", S_RD, 0);     chk("rst_redirect_pc", S_RDPC, 0);
    chk("rst_nbranch", S_NB, 0);      chk("rst_nmiss", S_NM, 0);
    fire();

    // Cold table
    cyc(32'h100); rst = 1'b0; #1;
    chk("cold_pred_taken", S_PT, 0); chk("cold_next_pc", S_NPC, 32'h104);
    chk("cold_nbranch", S_NB, 0); fire();

    // Allocation, with same-cycle fetch seeing the pre-edge (empty) entry
    cyc(32'h200); upd(32'h200, 1, 32'h180, 0, 0); #1;
    chk("alloc_redirect", S_RD, 1); chk("alloc_redirect_pc", S_RDPC, 32'h180);
    chk("alloc_next_pc", S_NPC, 32'h180); chk("alloc_no_writethru", S_PT, 0); fire();
    cyc(32'h200); #1;
    chk("alloc_hit_taken", S_PT, 1); chk("alloc_hit_target", S_PTGT, 32'h180);
    chk("alloc_hit_next_pc", S_NPC, 32'h180);
    chk("alloc_nmiss", S_NM, 1); chk("alloc_nbranch", S_NB, 1); fire();

    // Saturation up: ctr 2 -> 3 -> 3 -> 3
    for (int i = 0; i < 3; i++) begin
      cyc(32'h200); upd(32'h200, 1, 32'h180, 1, 32'h180); #1;
      chk("sat_up_no_redirect", S_RD, 0); fire();
    end
    cyc(32'h200); upd(32'h200, 0, 32'h0, 1, 32'h180); #1;
    chk("nt1_redirect", S_RD, 1); chk("nt1_redirect_pc", S_RDPC, 32'h204); fire();
    cyc(32'h200); #1;
    chk("hyst_ctr2_taken", S_PT, 1); chk("hyst_ctr2_next", S_NPC, 32'h180); fire();
    cyc(32'h200); upd(32'h200, 0, 32'h0, 1, 32'h180); #1;
    chk("nt2_presample_taken", S_PT, 1); fire();
    cyc(32'h200); #1;
    chk("hyst_ctr1_taken", S_PT, 0); chk("hyst_ctr1_next", S_NPC, 32'h204);
    chk("sat_nbranch", S_NB, 6); chk("sat_nmiss", S_NM, 3); fire();

    // Saturation down: ctr 1 -> 0 -> 0, then taken -> 1 (still not taken), -> 2
    for (int i = 0; i < 2; i++) begin
      cyc(32'h200); upd(32'h200, 0, 32'h0, 0, 32'h0); #1;
      chk("sat_dn_no_redirect", S_RD, 0); fire();
    end
    cyc(32'h200); upd(32'h200, 1, 32'h180, 0, 0);
    cyc(32'h200); #1;
    chk("sat_dn_ctr1", S_PT, 0); fire();
    cyc(32'h200); upd(32'h200, 1, 32'h180, 0, 0);
    cyc(32'h200); #1;
    chk("sat_dn_ctr2", S_PT, 1); chk("sat_dn_nbranch", S_NB, 10);
    chk("sat_dn_nmiss", S_NM, 5); fire();

    // Aliasing: 0x300 shares index 0 with 0x200
    cyc(32'h300); upd(32'h300, 1, 32'h40, 0, 0);
    cyc(32'h200); #1;
    chk("alias_old_miss", S_PT, 0); chk("alias_old_next", S_NPC, 32'h204); fire();
    cyc(32'h300); #1;
    chk("alias_new_taken", S_PT, 1); chk("alias_new_target", S_PTGT, 32'h40);
    chk("alias_new_next", S_NPC, 32'h40); fire();
    cyc(32'h300); upd(32'h300, 0, 0, 1, 32'h40); #1;
    chk("alias_nt_redirect_pc", S_RDPC, 32'h304); fire();
    cyc(32'h300); #1;
    chk("alias_init_ctr2", S_PT, 0); chk("alias_nmiss", S_NM, 7); chk("alias_nbranch", S_NB, 12); fire();

    // Wrong target
    cyc(32'h300); upd(32'h300, 1, 32'h1C0, 1, 32'h180); #1;
    chk("wt_redirect", S_RD, 1); chk("wt_redirect_pc", S_RDPC, 32'h1C0); fire();
    cyc(32'h300); #1;
    chk("wt_taken", S_PT, 1); chk("wt_new_target", S_PTGT, 32'h1C0); fire();
    cyc(32'h300); upd(32'h300, 1, 32'h1C0, 1, 32'h1C0); #1;
    chk("rt_no_redirect", S_RD, 0); fire();
    cyc(32'h300); upd(32'h500, 0, 32'h700, 0, 32'h123); #1;
    chk("nt_target_ignored", S_RD, 0); fire();
    cyc(32'h300); #1;
    chk("nt_miss_no_alloc", S_PT, 1); chk("nt_miss_target", S_PTGT, 32'h1C0); fire();
    cyc(32'h300); upd(32'hFFFF_FFFC, 0, 0, 1, 32'h80); #1;
    chk("wrap_redirect", S_RD, 1); chk("wrap_redirect_pc", S_RDPC, 32'h0); fire();
    cyc(32'hFFFF_FFFC); #1;
    chk("wrap_next_pc", S_NPC, 32'h0); chk("wrap_nbranch", S_NB, 16); chk("wrap_nmiss", S_NM, 9); fire();

    // Clock enable low
    cyc(32'h300); ce = 1'b0; upd(32'h600, 1, 32'h80, 0, 0); #1;
    chk("ce0_redirect", S_RD, 1); chk("ce0_next_pc", S_NPC, 32'h80); fire();
    cyc(32'h600); ce = 1'b1; #1;
    chk("ce0_no_alloc", S_PT, 0); chk("ce0_nbranch", S_NB, 16); chk("ce0_nmiss", S_NM, 9); fire();
    cyc(32'h300); #1;
    chk("ce0_entry_kept", S_PTGT, 32'h1C0); fire();

    // Reset asserted between edges, in the middle of an update
    cyc(32'h300); upd(32'h300, 1, 32'h40, 0, 0); #1;
    chk("pre_rst_redirect", S_RD, 1); fire();
    rst = 1'b1; #1;
    chk("mid_rst_nbranch", S_NB, 0); chk("mid_rst_nmiss", S_NM, 0);
    chk("mid_rst_pred", S_PT, 0); chk("mid_rst_ptgt", S_PTGT, 0);
    chk("mid_rst_next", S_NPC, 0); chk("mid_rst_redirect", S_RD, 0);
    chk("mid_rst_redirect_pc", S_RDPC, 0); fire();
    cyc(32'h300); rst = 1'b0; #1;
    chk("post_rst_miss", S_PT, 0); chk("post_rst_next", S_NPC, 32'h304); fire();
    cyc(32'h200); #1;
    chk("post_rst_empty", S_PT, 0); chk("post_rst_nbranch", S_NB, 0); fire();

    for (int i = 0; i < 10 && sb.size() > 0; i++) #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_if_bpred.md
Name: m_if_bpred

Overview:
- Branch-prediction front end for the 5-stage pipeline.
- Sits directly upstream of the IF stage and produces the next fetch PC each cycle.
- Uses a direct-mapped branch target buffer with 2-bit saturating direction counters.
- Trained by branch resolution from the Ex stage; signals a redirect when a resolved branch disagrees with the prediction it carried down the pipe.

Parameters:
IDX_W, 6, index bits; table has 2**IDX_W entries (default 64)
TAG_W, 6, tag bits taken from PC above the index
CTR_INIT, 2'b10, counter value written on allocation (weakly taken)

Ports:
w_clk  input  1  clock
w_rst  input  1  asynchronous reset, active-high
w_ce  input  1  clock enable; low = no state change
w_fetch_pc  input  32  PC being fetched this cycle (r_pc)
w_pred_taken  output  1  prediction for w_fetch_pc
w_pred_target  output  32  predicted target for w_fetch_pc
w_next_pc  output  32  PC to load into r_pc at next edge
w_upd_valid  input  1  a branch resolved in Ex this cycle
w_upd_pc  input  32  PC of resolved branch
w_upd_taken  input  1  actual direction
w_upd_target  input  32  actual taken target (IdEx_tpc)
w_upd_pred_taken  input  1  prediction carried with the branch
w_upd_pred_target  input  32  predicted target carried with the branch
w_redirect  output  1  misprediction; flush IfId/IdEx
w_redirect_pc  output  32  correct PC on redirect
w_nbranch  output  32  resolved-branch count
w_nmiss  output  32  misprediction count

Behaviour:
- Entry fields: valid, tag[TAG_W], target[31:2], ctr[1:0].
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] ignored.
- Lookup is combinational, zero latency.
  - hit = valid & tag match on w_fetch_pc.
  - w_pred_taken = hit & ctr[1].
  - w_pred_target = {target, 2'b00} on hit, else 0.
- w_redirect = w_upd_valid & (w_upd_taken != w_upd_pred_taken | (w_upd_taken & w_upd_target != w_upd_pred_target)).
- w_redirect_pc = w_upd_taken ? w_upd_target : w_upd_pc + 4.
- w_next_pc priority:
  1. w_redirect: w_redirect_pc
  2. w_pred_taken: w_pred_target
  3. otherwise: w_fetch_pc + 4
  - All +4 arithmetic is mod 2^32.
- Update at posedge when w_ce & w_upd_valid, using the index/tag of w_upd_pc:
  - Hit, taken: ctr = min(ctr+1, 3); target <= w_upd_target[31:2].
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss (invalid or tag mismatch), taken: allocate, overwriting any previous tag. Set valid=1, tag, target, ctr=CTR_INIT.
  - Miss, not taken: no table write.
- Counter saturation: 3 on taken stays 3; 0 on not-taken stays 0. There is no wrap.
- Same-cycle lookup and update to the same entry: lookup sees pre-edge contents; the new value is visible the following cycle. There is no write-through.
- Statistics:
  - w_nbranch +1 per w_ce & w_upd_valid.
  - w_nmiss +1 per w_ce & w_redirect.
  - Both wrap 0xFFFFFFFF -> 0.
- w_ce low: no table writes and counters hold. Combinational outputs still track their inputs.
- w_rst asserted (any time, including mid-update):
  - All valid bits, ctr fields, w_nbranch and w_nmiss go to 0 immediately.
  - While w_rst is high: w_pred_taken=0, w_pred_target=0, w_redirect=0, w_redirect_pc=0, w_next_pc=0.
  - The first cycle after deassertion behaves as a cold table: no hits, so w_next_pc = w_fetch_pc+4 unless a redirect occurs.
- Target field and tag are stored unconditionally on allocation. Entries are never invalidated except by reset.

Test Plan:
1. Cold table after reset: w_fetch_pc=0x100, no update -> w_pred_taken=0, w_next_pc=0x104, w_nbranch=0.
2. Allocation: update pc=0x200, taken=1, target=0x180, pred_taken=0 -> same cycle w_redirect=1, w_redirect_pc=0x180, w_next_pc=0x180. Next cycle, fetch 0x200 -> w_pred_taken=1, w_next_pc=0x180; w_nmiss=1, w_nbranch=1.
3. Saturation and hysteresis: three more taken updates at 0x200 -> ctr=3. One not-taken -> ctr=2, fetch 0x200 still predicts 0x180. Second not-taken -> ctr=1, fetch 0x200 gives w_next_pc=0x204.
4. Aliasing: with IDX_W=6, TAG_W=6, the entry for 0x200 is valid. Taken update at 0x300 (same index, different tag), target 0x40 -> entry replaced, ctr=2. Fetch 0x200 -> miss, w_next_pc=0x204.
5. Wrong-target redirect: upd_taken=1, pred_taken=1, pred_target=0x180, actual target=0x1C0 -> w_redirect=1, w_redirect_pc=0x1C0; stored target becomes 0x1C0. Not-taken mispredict at pc=0xFFFFFFFC -> w_redirect_pc=0x0.
6. Control: with w_ce=0, issue a taken update -> no table or counter change. Assert w_rst mid-cycle between edges -> counters read 0 before the next edge and the table is empty afterward.
